// File: rtl/rv32_muldiv.sv
// rv32_muldiv
// Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// Every operation runs a fixed sequence: 32 CALC iterations (radix-2
// shift-add or restoring divide on operand magnitudes), then one FIX cycle
// for sign correction and divide-by-zero override, then one DONE cycle.
//
// Handshake: a request is accepted on any rising edge where start_in = 1,
// flush_in = 0 and the unit is in IDLE or DONE (busy_out = 0). Operands and
// op are sampled only on that edge. busy_out stays high from the accept edge
// until DONE is entered. done_out pulses for exactly the DONE cycle, and
// result_out is valid then and holds until the next completed operation.
// flush_in forces IDLE on the next edge and has priority over start_in.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start_in   in   request strobe
//   op_in      in   funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   rs1_in     in   operand 1 (32 bits)
//   rs2_in     in   operand 2 (32 bits)
//   flush_in   in   abort any operation in flight
//   busy_out   out  operation in progress (CALC or FIX)
//   done_out   out  one-cycle completion pulse
//   result_out out  32-bit result
module rv32_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic [2:0]  op_in,
  input  logic [31:0] rs1_in,
  input  logic [31:0] rs2_in,
  input  logic        flush_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] result_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // state_q is the FSM state; checkers bind to it directly.
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [31:0] rs1_q, rs1_d;      // raw rs1, returned for REM by zero
  logic [31:0] b_q, b_d;          // |rs2|: multiplicand or divisor
  logic [63:0] acc_q, acc_d;      // mul: {product hi, multiplier/lo}; div: [31:0] dividend -> quotient
  logic [32:0] rem_q, rem_d;      // partial remainder
  logic [31:0] result_q, result_d;

  logic accept;
  assign accept = start_in && !flush_in && ((state_q == S_IDLE) || (state_q == S_DONE));

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    if (flush_in) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (start_in) state_d = S_CALC;
        S_CALC:  if (cnt_q == 6'd31) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  state_d = start_in ? S_CALC : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_out   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_out   = (state_q == S_DONE);
  assign result_out = result_q;

  // ---------------- operand decode ----------------
  logic        in_signed1, in_signed2;
  logic        in_sign1, in_sign2;
  logic [31:0] in_mag1, in_mag2;

  always_comb begin
    in_signed1 = 1'b0;
    in_signed2 = 1'b0;
    unique case (op_in)
      3'b000, 3'b001, 3'b100, 3'b110: begin  // MUL MULH DIV REM
        in_signed1 = 1'b1;
        in_signed2 = 1'b1;
      end
      3'b010:  in_signed1 = 1'b1;            // MULHSU
      default: ;                             // MULHU DIVU REMU
    endcase
  end

  assign in_sign1 = in_signed1 & rs1_in[31];
  assign in_sign2 = in_signed2 & rs2_in[31];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign in_mag1  = in_sign1 ? (~rs1_in + 32'd1) : rs1_in;
  assign in_mag2  = in_sign2 ? (~rs2_in + 32'd1) : rs2_in;

  // ---------------- iteration datapath ----------------
  logic [32:0] mul_sum;
  logic [33:0] div_trial;
  logic        div_borrow;

  // Shift-add: add multiplicand to the high half when the current multiplier
  // bit is set, then shift the 65-bit {carry, hi, lo} right by one.
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? b_q : 32'd0)};

  // Restoring divide: shift the next dividend bit into the remainder and
  // keep the difference only if it did not borrow.
  assign div_trial  = {rem_q, acc_q[31]} - {2'b00, b_q};
  assign div_borrow = div_trial[33];

  // ---------------- sign fix-up ----------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, mul_res, div_res, fix_res;

  assign prod_fix = (sign1_q ^ sign2_q) ? (~acc_q + 64'd1) : acc_q;
  assign quot_fix = (sign1_q ^ sign2_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = sign1_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
  assign mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];

  always_comb begin
    if (b_q == 32'd0) begin
      // b_q is zero exactly when rs2 was zero.
      div_res = op_q[1] ? rs1_q : 32'hFFFF_FFFF;
    end else begin
      div_res = op_q[1] ? rem_fix : quot_fix;
    end
  end

  assign fix_res = op_q[2] ? div_res : mul_res;

  // ---------------- next-state datapath ----------------
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    rs1_d    = rs1_q;
    b_d      = b_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;

    if (accept) begin
      cnt_d   = 6'd0;
      op_d    = op_in;
      sign1_d = in_sign1;
      sign2_d = in_sign2;
      rs1_d   = rs1_in;
      b_d     = in_mag2;
      acc_d   = {32'd0, in_mag1};
      rem_d   = 33'd0;
    end else if (!flush_in && (state_q == S_CALC)) begin
      cnt_d = cnt_q + 6'd1;
      if (op_q[2]) begin
        rem_d = div_borrow ? {rem_q[31:0], acc_q[31]} : div_trial[32:0];
        acc_d = {acc_q[63:32], acc_q[30:0], ~div_borrow};
      end else begin
        acc_d = {mul_sum, acc_q[31:1]};
      end
    end else if (!flush_in && (state_q == S_FIX)) begin
      result_d = fix_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      rs1_q    <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      rem_q    <= 33'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      rs1_q    <= rs1_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rv32_muldiv.sv
module tb_rv32_muldiv;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [2:0]  op_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        flush_in;
  logic        busy_out;
  logic        done_out;
  logic [31:0] result_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  rv32_muldiv dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .op_in      (op_in),
    .rs1_in     (rs1_in),
    .rs2_in     (rs2_in),
    .flush_in   (flush_in),
    .busy_out   (busy_out),
    .done_out   (done_out),
    .result_out (result_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst_n    = 1'b0;
    start_in = 1'b0;
    op_in    = 3'd0;
    rs1_in   = 32'd0;
    rs2_in   = 32'd0;
    flush_in = 1'b0;
  end

  // ---------------- driver ----------------
  // Issues one request and waits (bounded) for done_out. lat counts rising
  // edges after the accept edge until done_out is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output logic busy_first, output logic busy_at_done);
    @(negedge clk);
    start_in = 1'b1;
    op_in    = op;
    rs1_in   = a;
    rs2_in   = b;
    @(negedge clk);
    start_in   = 1'b0;
    rs1_in     = $urandom;
    rs2_in     = $urandom;
    busy_first = busy_out;
    lat = 0;
    while (done_out !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    res          = result_out;
    busy_at_done = busy_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_out);
    else pass_cnt++;
    chk_cnt++;
    if (done_out !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_out);
    else pass_cnt++;
    chk_cnt++;
    if (result_out !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result_out);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4] = '{OP_MUL, OP_MULHU, OP_MULH, OP_MULHSU};
    logic [31:0] as  [4] = '{32'h0000_0007, 32'h0000_0007, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] exps[4] = '{32'hFFFF_FFEB, 32'h0000_0006, 32'h4000_0000, 32'hFFFF_FFFF};
    int lat;
    logic [31:0] res;
    logic bf, bd;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, bf, bd);
      chk_cnt++;
      if (bf !== 1'b1) $display("FAIL mul%0d_busy: got %b expected 1", i, bf);
      else pass_cnt++;
      chk_cnt++;
      if (lat != 33) $display("FAIL mul%0d_latency: got %0d expected 33", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (res !== exps[i]) $display("FAIL mul%0d_result: got %h expected %h", i, res, exps[i]);
      else pass_cnt++;
      chk_cnt++;
      if (bd !== 1'b0) $display("FAIL mul%0d_busy_done: got %b expected 0", i, bd);
      else pass_cnt++;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [7] = '{OP_DIV, OP_REM, OP_DIVU, OP_DIV, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as  [7] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h0000_0005,
                             32'h0000_0005, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [7] = '{32'h0000_0002, 32'h0000_0002, 32'h0000_0010, 32'h0000_0000,
                             32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exps[7] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
    int lat;
    logic [31:0] res;
    logic bf, bd;
    for (int i = 0; i < 7; i++) begin
      run_op(ops[i], as[i], bs[i], lat, res, bf, bd);
      chk_cnt++;
      if (lat != 33) $display("FAIL div%0d_latency: got %0d expected 33", i, lat);
      else pass_cnt++;
      chk_cnt++;
      if (res !== exps[i]) $display("FAIL div%0d_result: got %h expected %h", i, res, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    start_in = 1'b1;
    op_in    = OP_MUL;
    rs1_in   = 32'h0000_0007;
    rs2_in   = 32'hFFFF_FFFD;
    @(negedge clk);
    // start_in stays high through CALC and FIX; it must be ignored there.
    lat = 0;
    while (done_out !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat != 33) $display("FAIL b2b_held_latency: got %0d expected 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (result_out !== 32'hFFFF_FFEB) $display("FAIL b2b_first_result: got %h expected ffffffeb", result_out);
    else pass_cnt++;
    // New operands presented in the DONE cycle with start still high.
    op_in  = OP_DIVU;
    rs1_in = 32'hFFFF_FFFF;
    rs2_in = 32'h0000_0010;
    @(negedge clk);
    start_in = 1'b0;
    chk_cnt++;
    if (busy_out !== 1'b1) $display("FAIL b2b_accept_busy: got %b expected 1", busy_out);
    else pass_cnt++;
    chk_cnt++;
    if (done_out !== 1'b0) $display("FAIL b2b_done_drop: got %b expected 0", done_out);
    else pass_cnt++;
    lat = 0;
    while (done_out !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_cnt++;
    if (lat != 33) $display("FAIL b2b_second_latency: got %0d expected 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (result_out !== 32'h0FFF_FFFF) $display("FAIL b2b_second_result: got %h expected 0fffffff", result_out);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    logic seen_done;
    @(negedge clk);
    start_in = 1'b1;
    op_in    = OP_MUL;
    rs1_in   = 32'h0000_0003;
    rs2_in   = 32'h0000_0005;
    @(negedge clk);
    start_in = 1'b0;
    repeat (20) @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    chk_cnt++;
    if (busy_out !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy_out);
    else pass_cnt++;
    seen_done = 1'b0;
    repeat (40) begin
      if (done_out === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    chk_cnt++;
    if (seen_done !== 1'b0) $display("FAIL flush_no_done: got %b expected 0", seen_done);
    else pass_cnt++;
    chk_cnt++;
    if (result_out !== 32'h0FFF_FFFF) $display("FAIL flush_result_hold: got %h expected 0fffffff", result_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    int lat;
    logic [31:0] res;
    logic bf, bd;
    @(negedge clk);
    start_in = 1'b1;
    op_in    = OP_DIV;
    rs1_in   = 32'hFFFF_FFF9;
    rs2_in   = 32'h0000_0002;
    @(negedge clk);
    start_in = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (busy_out !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy_out);
    else pass_cnt++;
    chk_cnt++;
    if (done_out !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done_out);
    else pass_cnt++;
    chk_cnt++;
    if (result_out !== 32'h0) $display("FAIL rstmid_result: got %h expected 00000000", result_out);
    else pass_cnt++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_out === 1'b1) seen_done = 1'b1;
    end
    chk_cnt++;
    if (seen_done !== 1'b0) $display("FAIL rstmid_no_done: got %b expected 0", seen_done);
    else pass_cnt++;
    run_op(OP_MULHU, 32'h0000_0007, 32'hFFFF_FFFD, lat, res, bf, bd);
    chk_cnt++;
    if (lat != 33) $display("FAIL rstmid_next_latency: got %0d expected 33", lat);
    else pass_cnt++;
    chk_cnt++;
    if (res !== 32'h0000_0006) $display("FAIL rstmid_next_result: got %h expected 00000006", res);
    else pass_cnt++;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rv32_muldiv.md
# rv32_muldiv

Iterative RV32M multiply/divide unit beside the EX-stage ALU. It accepts one M-extension operation per request from the EX stage. It computes the result over a fixed 32-iteration shift-add or restoring-divide sequence, holding the pipeline with `busy_out` while it runs. It returns the 32-bit result with a one-cycle `done_out` pulse for the EX/MEM register to capture.

## Interface
Parameters: none. Operand width is fixed at 32.

- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start_in`  in  1  request strobe from EX; sampled only when the unit is accepting
- `op_in`  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_in`  in  32  operand 1; sampled on the accept edge
- `rs2_in`  in  32  operand 2; sampled on the accept edge
- `flush_in`  in  1  pipeline flush; aborts any operation in flight
- `busy_out`  out  1  high while an operation is in progress; EX stalls on it
- `done_out`  out  1  one-cycle pulse; `result_out` is valid in this cycle
- `result_out`  out  32  result; holds its value until the next accepted request completes

## Operation
- State machine: IDLE, CALC, FIX, DONE.
- IDLE → CALC on `start_in` = 1. On that edge, latch `op_in`, the operand signs, and the operand magnitudes, and clear the 6-bit iteration counter.
- CALC runs exactly 32 iterations. The counter increments every cycle, and CALC → FIX when the counter reaches 31.
- FIX → DONE after exactly one cycle. DONE lasts one cycle; DONE → IDLE unless a new start is accepted.
- Accepting states are IDLE and DONE. `start_in` in DONE begins a new operation back-to-back (DONE → CALC). `start_in` in CALC or FIX is ignored.
- `busy_out` = 1 in CALC and FIX, 0 in IDLE and DONE. `done_out` = 1 only in DONE.
- `flush_in` = 1 forces IDLE on the next edge from any state and suppresses `done_out`. `result_out` is not updated. Flush has priority over start in the same cycle.

Multiply:
- Operands are treated as signed or unsigned per op: MUL/MULH both signed, MULHSU rs1 signed / rs2 unsigned, MULHU both unsigned.
- Unsigned radix-2 shift-add on the magnitudes builds a 64-bit product.
- In FIX, negate the 64-bit product (two's complement) if exactly one signed operand is negative.
- Result: MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].

Divide:
- DIV/REM take signed magnitudes; DIVU/REMU are unsigned.
- Restoring division on the magnitudes runs 32 iterations with a 33-bit partial remainder.
- In FIX, the quotient is negated if sign1 ^ sign2, and the remainder is negated if sign1.
- Divide by zero (rs2 = 0) overrides the computed value in FIX: DIV/DIVU → 0xFFFFFFFF, REM/REMU → rs1 as sampled.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. This falls out of the magnitude algorithm and needs no special case, but it must hold.
- Divide by zero and overflow take the same 32-iteration latency; there is no early exit.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `busy_out` 0, `done_out` 0, `result_out` 0x00000000, counter 0, internal registers 0. Reset in the middle of an operation abandons it with no `done_out`.
- Accept edge E0. `busy_out` = 1 from E0 through E0+33. DONE is entered at E0+33, so `done_out` = 1 and `result_out` is valid in the cycle after E0+33.
- Latency: 33 edges from accept to `done_out`. Back-to-back throughput: one operation per 34 cycles.
- `result_out` is registered on the edge entering DONE. It is stable from that point until the next DONE.
- Operand inputs are don't-care outside the accept edge.

## Test plan
- Reset mid-CALC: assert `rst_n` low 10 cycles after a start → all outputs 0 immediately, no `done_out` after release, next start behaves normally.
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD) → `done_out` exactly 33 edges after accept, `result_out` 0xFFFFFFEB. The same operands with MULHU → 0x00000006.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD. REM -7 / 2 → 0xFFFFFFFF. DIVU 0xFFFFFFFF / 0x10 → 0x0FFFFFFF.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REMU 5/0 → 0x00000005. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0. All complete with the standard latency.
- Handshake: `start_in` held high throughout CALC is ignored. A new start in the DONE cycle is accepted (`busy_out` high the next cycle). `flush_in` at iteration 20 → IDLE next cycle, no `done_out`, `result_out` unchanged.
